// File: rtl/base_afork_if.sv
// rtl/base_afork_if.sv - valid/ready bundle for the eager fork stage: one input stream, no output streams
interface base_afork_if #(
    parameter int width = 8,
    parameter int no    = 2
);
    logic             i_v;
    logic             i_r;
    logic [0:width-1] i_d;
    logic [0:no-1]    o_v;
    logic [0:no-1]    o_r;
    logic [0:width-1] o_d;
    logic             s_busy;

    modport master (
        output i_v, i_d, o_r,
        input  i_r, o_v, o_d, s_busy
    );

    modport slave (
        input  i_v, i_d, o_r,
        output i_r, o_v, o_d, s_busy
    );
endinterface

// File: rtl/base_afork.sv
// rtl/base_afork.sv - registered eager fork: one held beat offered to every output, freed after all have taken it
module base_afork #(
    parameter int width = 8,
    parameter int no    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    base_afork_if.slave  bus
);
    logic             full_q, full_d;
    logic [0:width-1] dat_q, dat_d;
    logic [0:no-1]    pend_q, pend_d;

    logic [0:no-1]    take;
    logic             last;
    logic             in_rdy;
    logic             accept;

    // The only combinational path is o_r -> i_r: a new beat may load on the
    // same edge that the final pending output takes the current one.
    always_comb begin
        take   = pend_q & bus.o_r;
        last   = full_q && ((pend_q & ~take) == '0);
        in_rdy = rst_n && (!full_q || last);
        accept = bus.i_v && in_rdy;

        full_d = full_q;
        dat_d  = dat_q;
        pend_d = pend_q & ~take;
        if (accept) begin
            full_d = 1'b1;
            dat_d  = bus.i_d;
            pend_d = '1;
        end else if (last) begin
            full_d = 1'b0;
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            dat_q  <= '0;
            pend_q <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
            pend_q <= pend_d;
        end
    end

    assign bus.i_r    = in_rdy;
    assign bus.o_v    = pend_q;
    assign bus.o_d    = dat_q;
    assign bus.s_busy = full_q;
endmodule
